frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Top-level frame sequencer for the plotter pipeline. On each frame request it pulses `fill_drawer` to clear the back buffer, then pulses `logic_placeholder`, which drives `line_drawer`. It waits for vertical blanking and then issues a one-cycle `swap` to `frame_buffer`. It also owns the single frame-buffer write port and replaces the ad-hoc OR of drawer write buses with a state-based grant mux that detects conflicts.

## Interface
Parameters:
- `FB_ADDR_WIDTH`, 19, frame-buffer address width (640×480 = 307200 pixels).
- `FRAME_COUNT_WIDTH`, 16, width of the completed-frame counter.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle frame request.
- `vblank`  in  1  high while the display is in vertical blanking.
- `busy`  out  1  high from frame acceptance until `frame_done`.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `frame_count`  out  FRAME_COUNT_WIDTH  number of completed frames, wraps.
- `conflict`  out  1  sticky; set when a non-granted drawer writes.
- `fill_start`  out  1  start pulse to `fill_drawer`.
- `fill_ready`  in  1  `fill_drawer` idle.
- `logic_start`  out  1  start pulse to `logic_placeholder`.
- `logic_ready`  in  1  `logic_placeholder` idle.
- `swap`  out  1  buffer-swap pulse to `frame_buffer`.
- `fill_we`, `fill_addr`, `fill_data`  in  1/FB_ADDR_WIDTH/1  `fill_drawer` write bus.
- `line_we`, `line_addr`, `line_data`  in  1/FB_ADDR_WIDTH/1  `line_drawer` write bus.
- `fb_we`, `fb_addr`, `fb_data`  out  1/FB_ADDR_WIDTH/1  arbitrated frame-buffer write bus.

## Operation
- States: IDLE, FILL_START, FILL_SETTLE, FILL_WAIT, LOGIC_START, LOGIC_SETTLE, LOGIC_WAIT, SWAP_WAIT, SWAP, DONE.
- Pending request:
  - `pending` is a one-deep flag, set by `frame_start` in any state.
  - It is cleared when IDLE accepts a frame.
  - Further requests while it is already set are dropped.
- IDLE → FILL_START when (`pending` or `frame_start`) and `fill_ready` and `logic_ready`.
  - If either ready is low, the request stays pending.
- FILL_START: `fill_start`=1 for one cycle → FILL_SETTLE.
- FILL_SETTLE: one cycle in which ready is ignored, because the drawer's ready may lag its start by a cycle → FILL_WAIT.
- FILL_WAIT: stays until `fill_ready`=1 → LOGIC_START.
- LOGIC_START / LOGIC_SETTLE / LOGIC_WAIT: same pattern using `logic_start` and `logic_ready` → SWAP_WAIT.
- SWAP_WAIT: stays until `vblank`=1 → SWAP. If `vblank` is already high on entry, exit on the next edge.
- SWAP: `swap`=1 for one cycle → DONE.
- DONE: `frame_done`=1 for one cycle, `frame_count`+1 modulo 2^FRAME_COUNT_WIDTH → IDLE.
- Write grant (combinational, zero latency):
  - Fill states: `fb_*` = `fill_*`.
  - Logic states: `fb_*` = `line_*`.
  - All other states: `fb_*` = 0.
- `conflict` is set on any cycle in which the non-granted `*_we`=1, or either `*_we`=1 in IDLE/SWAP_WAIT/SWAP/DONE. It is cleared only by reset. Conflicting writes never reach `fb_*`.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: all outputs 0, state IDLE, `pending`=0, `frame_count`=0.
- Reset mid-frame:
  - The scheduler returns to IDLE immediately.
  - It does not reset the drawers, which have no reset.
  - Restart is blocked by the both-ready check until both drawers report idle.
- `frame_start` with both readies high → `fill_start` at edge +1. The `frame_start` cycle itself is IDLE.
- Minimum frame length with drawers ready immediately and `vblank` high: 10 cycles from `frame_start` to `frame_done`.
- `swap` and `frame_done` are in consecutive cycles and never coincide with any granted write.
- `frame_start` arriving in the DONE cycle is captured in `pending`; the next frame begins one cycle after IDLE is re-entered.

## Structure
- Package `plotter_pkg` holds:
  - the state enum;
  - `SCREEN_WIDTH`=640, `SCREEN_HEIGHT`=480, `FB_ADDR_WIDTH`=19.
- Sub-module `fb_write_mux`: combinational grant mux plus conflict detect. Inputs are the two write buses and a 2-bit grant select; outputs are the arbitrated bus and a conflict strobe. The sticky `conflict` register lives in `frame_scheduler`.
- Drop-in for the bench wiring: `fb_*` replaces the OR of drawer write signals.

## Test plan
- Reset, then `frame_start` with behavioural drawers (ready drops 2 cycles after start, busy 5 cycles) and `vblank`=1:
  - exactly one each of `fill_start`, `logic_start`, `swap` and `frame_done`, in that order;
  - `frame_count`=1.
- `vblank` held 0 for 100 cycles after LOGIC_WAIT exits → `swap` stays 0; `swap` pulses on the first edge after `vblank` rises.
- Three `frame_start` pulses during one frame → exactly two frames complete; `frame_count`=2.
- `line_we`=1 during FILL_WAIT at addr 0x12345 → `fb_we`=0 that cycle and `conflict`=1 afterwards.
- `fill_ready`=0 at request → nothing starts and `busy`=0; `fill_ready` rises → `fill_start` on the next edge.
- `rst_n` low during LOGIC_WAIT → all outputs 0 asynchronously; `frame_count`=0 after release.
- Integration with the real drawers and `frame_buffer`:
  - the dumped frame is identical to the current bench output;
  - `conflict`=0.

Source files
------------

// File: rtl/plotter_pkg.sv
// Shared types and constants for the plotter pipeline: scheduler states,
// write-grant encoding and screen geometry.
package plotter_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int FB_ADDR_WIDTH = 19;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    FILL_START   = 4'd1,
    FILL_SETTLE  = 4'd2,
    FILL_WAIT    = 4'd3,
    LOGIC_START  = 4'd4,
    LOGIC_SETTLE = 4'd5,
    LOGIC_WAIT   = 4'd6,
    SWAP_WAIT    = 4'd7,
    SWAP         = 4'd8,
    DONE         = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_FILL = 2'd1,
    GRANT_LINE = 2'd2
  } grant_e;

  // Which drawer owns the frame-buffer write port in a given scheduler state.
  function automatic grant_e grant_for(state_e s);
    case (s)
      FILL_START, FILL_SETTLE, FILL_WAIT:    grant_for = GRANT_FILL;
      LOGIC_START, LOGIC_SETTLE, LOGIC_WAIT: grant_for = GRANT_LINE;
      default:                               grant_for = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Scheduler-side bundle: frame request/status, drawer handshakes and the
// three frame-buffer write buses.
//
// Drawer handshake: *_ready high means the drawer is idle. The scheduler
// raises *_start for exactly one cycle, only after it has seen *_ready high;
// the drawer may keep ready high for one more cycle before dropping it, and
// raises it again when its work is finished.
interface frame_scheduler_if #(
  parameter int FB_ADDR_WIDTH     = plotter_pkg::FB_ADDR_WIDTH,
  parameter int FRAME_COUNT_WIDTH = 16
);
  logic                         frame_start;
  logic                         vblank;
  logic                         busy;
  logic                         frame_done;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count;
  logic                         conflict;
  logic                         fill_start;
  logic                         fill_ready;
  logic                         logic_start;
  logic                         logic_ready;
  logic                         swap;
  logic                         fill_we;
  logic [FB_ADDR_WIDTH-1:0]     fill_addr;
  logic                         fill_data;
  logic                         line_we;
  logic [FB_ADDR_WIDTH-1:0]     line_addr;
  logic                         line_data;
  logic                         fb_we;
  logic [FB_ADDR_WIDTH-1:0]     fb_addr;
  logic                         fb_data;

  modport master (
    input  frame_start, vblank, fill_ready, logic_ready,
    input  fill_we, fill_addr, fill_data, line_we, line_addr, line_data,
    output busy, frame_done, frame_count, conflict,
    output fill_start, logic_start, swap, fb_we, fb_addr, fb_data
  );

  modport slave (
    output frame_start, vblank, fill_ready, logic_ready,
    output fill_we, fill_addr, fill_data, line_we, line_addr, line_data,
    input  busy, frame_done, frame_count, conflict,
    input  fill_start, logic_start, swap, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/fb_write_mux.sv
// Grant-driven frame-buffer write mux. Only the granted drawer reaches the
// output bus; a write from anyone else raises a one-cycle conflict strobe.
module fb_write_mux #(
  parameter int FB_ADDR_WIDTH = plotter_pkg::FB_ADDR_WIDTH
) (
  input  plotter_pkg::grant_e     grant,
  input  logic                    fill_we,
  input  logic [FB_ADDR_WIDTH-1:0] fill_addr,
  input  logic                    fill_data,
  input  logic                    line_we,
  input  logic [FB_ADDR_WIDTH-1:0] line_addr,
  input  logic                    line_data,
  output logic                    fb_we,
  output logic [FB_ADDR_WIDTH-1:0] fb_addr,
  output logic                    fb_data,
  output logic                    conflict_strobe
);
  import plotter_pkg::*;

  // Pass the granted bus through; flag any write from a non-granted source.
  always_comb begin
    fb_we           = 1'b0;
    fb_addr         = '0;
    fb_data         = 1'b0;
    conflict_strobe = 1'b0;
    case (grant)
      GRANT_FILL: begin
        fb_we           = fill_we;
        fb_addr         = fill_addr;
        fb_data         = fill_data;
        conflict_strobe = line_we;
      end
      GRANT_LINE: begin
        fb_we           = line_we;
        fb_addr         = line_addr;
        fb_data         = line_data;
        conflict_strobe = fill_we;
      end
      default: conflict_strobe = fill_we | line_we;
    endcase
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame sequencer: clear (fill) -> draw (logic/line) -> wait vblank -> swap.
// Owns the single frame-buffer write port through a state-based grant mux.
module frame_scheduler #(
  parameter int FB_ADDR_WIDTH     = plotter_pkg::FB_ADDR_WIDTH,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  frame_scheduler_if.master   bus,
  output plotter_pkg::state_e state_dbg
);
  import plotter_pkg::*;

  state_e                       state_q;
  state_e                       state_d;
  logic                         pending_q;
  logic [FRAME_COUNT_WIDTH-1:0] count_q;
  logic                         conflict_q;
  logic                         conflict_strobe;
  logic                         accept;
  grant_e                       grant;

  // A frame starts only when both drawers are idle; otherwise it stays pending.
  assign accept = (state_q == IDLE) && (pending_q || bus.frame_start) &&
                  bus.fill_ready && bus.logic_ready;

  // Next-state logic; the SETTLE states ignore ready for one cycle because a
  // drawer's ready may lag its start pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (accept) state_d = FILL_START;
      FILL_START:   state_d = FILL_SETTLE;
      FILL_SETTLE:  state_d = FILL_WAIT;
      FILL_WAIT:    if (bus.fill_ready) state_d = LOGIC_START;
      LOGIC_START:  state_d = LOGIC_SETTLE;
      LOGIC_SETTLE: state_d = LOGIC_WAIT;
      LOGIC_WAIT:   if (bus.logic_ready) state_d = SWAP_WAIT;
      SWAP_WAIT:    if (bus.vblank) state_d = SWAP;
      SWAP:         state_d = DONE;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // One-deep request latch; extra requests while it is set are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pending_q <= 1'b0;
    else if (accept)          pending_q <= 1'b0;
    else if (bus.frame_start) pending_q <= 1'b1;
  end

  // Completed-frame counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                count_q <= '0;
    else if (state_q == DONE)  count_q <= count_q + FRAME_COUNT_WIDTH'(1);
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               conflict_q <= 1'b0;
    else if (conflict_strobe) conflict_q <= 1'b1;
  end

  // Write grant follows the current state with zero latency.
  always_comb begin
    grant = grant_for(state_q);
  end

  fb_write_mux #(.FB_ADDR_WIDTH(FB_ADDR_WIDTH)) u_mux (
    .grant           (grant),
    .fill_we         (bus.fill_we),
    .fill_addr       (bus.fill_addr),
    .fill_data       (bus.fill_data),
    .line_we         (bus.line_we),
    .line_addr       (bus.line_addr),
    .line_data       (bus.line_data),
    .fb_we           (bus.fb_we),
    .fb_addr         (bus.fb_addr),
    .fb_data         (bus.fb_data),
    .conflict_strobe (conflict_strobe)
  );

  assign bus.busy        = (state_q != IDLE);
  assign bus.fill_start  = (state_q == FILL_START);
  assign bus.logic_start = (state_q == LOGIC_START);
  assign bus.swap        = (state_q == SWAP);
  assign bus.frame_done  = (state_q == DONE);
  assign bus.frame_count = count_q;
  assign bus.conflict    = conflict_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler with behavioural fill/logic drawers and an
// event scoreboard for the start/swap/done pulses.
module tb_frame_scheduler;
  import plotter_pkg::*;

  localparam int AW = 19;
  localparam int CW = 16;
  localparam int W  = 20;
  localparam logic [3:0] EV_FILL  = 4'd1;
  localparam logic [3:0] EV_LOGIC = 4'd2;
  localparam logic [3:0] EV_SWAP  = 4'd3;
  localparam logic [3:0] EV_DONE  = 4'd4;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_e state_dbg;

  always #5 clk = ~clk;

  frame_scheduler_if #(.FB_ADDR_WIDTH(AW), .FRAME_COUNT_WIDTH(CW)) bus ();

  frame_scheduler #(.FB_ADDR_WIDTH(AW), .FRAME_COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural drawers ----------------
  // Ready stays high one cycle after start, then is low for 5 cycles.
  int   f_age = 0;
  int   l_age = 0;
  logic fill_hold = 1'b0;
  logic f_seen, l_seen;

  assign bus.fill_ready  = !fill_hold && !(f_age >= 2 && f_age <= 6);
  assign bus.logic_ready = !(l_age >= 2 && l_age <= 6);

  always @(posedge clk) begin
    f_seen = bus.fill_start;
    l_seen = bus.logic_start;
    #1;
    if (f_seen) f_age = 1;
    else if (f_age != 0 && f_age < 7) f_age = f_age + 1;
    else f_age = 0;
    if (l_seen) l_age = 1;
    else if (l_age != 0 && l_age < 7) l_age = l_age + 1;
    else l_age = 0;
  end

  // ---------------- scoreboard monitor ----------------
  task automatic sb_pop(string name, logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      check_cnt++;
      $display("FAIL %s: unexpected event 0x%0h, none expected", name, got);
    end else begin
      check(name, got, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fill_start)  sb_pop("ev_fill_start",  {EV_FILL,  bus.frame_count});
      if (bus.logic_start) sb_pop("ev_logic_start", {EV_LOGIC, bus.frame_count});
      if (bus.swap)        sb_pop("ev_swap",        {EV_SWAP,  bus.frame_count});
      if (bus.frame_done)  sb_pop("ev_frame_done",  {EV_DONE,  bus.frame_count});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(logic [CW-1:0] cnt);
    exp_q.push_back({EV_FILL,  cnt});
    exp_q.push_back({EV_LOGIC, cnt});
    exp_q.push_back({EV_SWAP,  cnt});
    exp_q.push_back({EV_DONE,  cnt});
  endtask

  task automatic pulse_start();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_state(state_e s, string name, int budget);
    int n = 0;
    while (state_dbg != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, state_dbg, s);
  endtask

  // ---------------- stimulus ----------------
  int n_swap;

  initial begin
    bus.frame_start = 1'b0;
    bus.vblank      = 1'b1;
    bus.fill_we     = 1'b0;
    bus.fill_addr   = '0;
    bus.fill_data   = 1'b0;
    bus.line_we     = 1'b0;
    bus.line_addr   = '0;
    bus.line_data   = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy",        bus.busy, 0);
    check("rst_frame_done",  bus.frame_done, 0);
    check("rst_frame_count", bus.frame_count, 0);
    check("rst_conflict",    bus.conflict, 0);
    check("rst_fill_start",  bus.fill_start, 0);
    check("rst_logic_start", bus.logic_start, 0);
    check("rst_swap",        bus.swap, 0);
    check("rst_fb_we",       bus.fb_we, 0);
    check("rst_state",       state_dbg, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame with vblank already high
    push_frame(16'd0);
    pulse_start();
    check("t1_fill_start_latency", bus.fill_start, 1);
    wait_state(DONE, "t1_reach_done", 80);
    @(negedge clk);
    check("t1_frame_count", bus.frame_count, 1);
    check("t1_busy_after",  bus.busy, 0);

    // vblank held low: swap must wait, then fire on the first edge
    bus.vblank = 1'b0;
    push_frame(16'd1);
    pulse_start();
    wait_state(SWAP_WAIT, "t2_reach_swap_wait", 80);
    n_swap = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.swap) n_swap++;
    end
    check("t2_swap_held_low", n_swap, 0);
    check("t2_still_swap_wait", state_dbg, SWAP_WAIT);
    bus.vblank = 1'b1;
    @(posedge clk);
    #1;
    check("t2_swap_first_edge", bus.swap, 1);
    wait_state(DONE, "t2_reach_done", 10);
    @(negedge clk);
    check("t2_frame_count", bus.frame_count, 2);

    // Three requests inside one frame -> two frames
    push_frame(16'd2);
    push_frame(16'd3);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    wait_state(DONE, "t3_reach_done_a", 80);
    @(negedge clk);
    check("t3_count_a", bus.frame_count, 3);
    wait_state(DONE, "t3_reach_done_b", 80);
    @(negedge clk);
    check("t3_count_b", bus.frame_count, 4);
    repeat (20) @(negedge clk);
    check("t3_count_final", bus.frame_count, 4);
    check("t3_busy_final",  bus.busy, 0);

    // Write grant and conflict detection
    check("t4_conflict_clear", bus.conflict, 0);
    push_frame(16'd4);
    pulse_start();
    wait_state(FILL_WAIT, "t4_reach_fill_wait", 20);
    bus.line_we   = 1'b1;
    bus.line_addr = 19'h12345;
    bus.line_data = 1'b1;
    #1;
    check("t4_blocked_fb_we",   bus.fb_we, 0);
    check("t4_blocked_fb_addr", bus.fb_addr, 0);
    check("t4_conflict_not_yet", bus.conflict, 0);
    @(negedge clk);
    bus.line_we   = 1'b0;
    bus.fill_we   = 1'b1;
    bus.fill_addr = 19'h0AAAA;
    bus.fill_data = 1'b1;
    #1;
    check("t4_conflict_set",   bus.conflict, 1);
    check("t4_fill_fb_we",     bus.fb_we, 1);
    check("t4_fill_fb_addr",   bus.fb_addr, 32'h0AAAA);
    check("t4_fill_fb_data",   bus.fb_data, 1);
    @(negedge clk);
    bus.fill_we   = 1'b0;
    bus.fill_addr = '0;
    bus.fill_data = 1'b0;
    wait_state(LOGIC_WAIT, "t4_reach_logic_wait", 30);
    bus.line_we   = 1'b1;
    bus.line_addr = 19'h01234;
    bus.line_data = 1'b1;
    #1;
    check("t4_line_fb_we",   bus.fb_we, 1);
    check("t4_line_fb_addr", bus.fb_addr, 32'h01234);
    @(negedge clk);
    bus.line_we   = 1'b0;
    bus.line_addr = '0;
    bus.line_data = 1'b0;
    wait_state(DONE, "t4_reach_done", 40);
    @(negedge clk);
    check("t4_frame_count", bus.frame_count, 5);
    check("t4_conflict_sticky", bus.conflict, 1);

    // Request while fill drawer is busy stays pending
    fill_hold = 1'b1;
    @(negedge clk);
    push_frame(16'd5);
    pulse_start();
    repeat (4) @(negedge clk);
    check("t5_busy_held",       bus.busy, 0);
    check("t5_fill_start_held", bus.fill_start, 0);
    fill_hold = 1'b0;
    @(posedge clk);
    #1;
    check("t5_fill_start_next_edge", bus.fill_start, 1);
    wait_state(DONE, "t5_reach_done", 80);
    @(negedge clk);
    check("t5_frame_count", bus.frame_count, 6);

    // Asynchronous reset during LOGIC_WAIT
    exp_q.push_back({EV_FILL,  16'd6});
    exp_q.push_back({EV_LOGIC, 16'd6});
    pulse_start();
    wait_state(LOGIC_WAIT, "t6_reach_logic_wait", 30);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",        bus.busy, 0);
    check("t6_rst_frame_count", bus.frame_count, 0);
    check("t6_rst_conflict",    bus.conflict, 0);
    check("t6_rst_logic_start", bus.logic_start, 0);
    check("t6_rst_state",       state_dbg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_count_after_release", bus.frame_count, 0);
    push_frame(16'd0);
    pulse_start();
    check("t6_restart_blocked", bus.busy, 0);
    wait_state(DONE, "t6_reach_done", 80);
    @(negedge clk);
    check("t6_frame_count", bus.frame_count, 1);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
